line_mem_scheduler: RTL and testbench

// - Shares one 256-bit line port (cacheline adapter side) between the I-cache (read-only) and the D-cache (read/write).
// - Sits between the two caches' pmem ports and the cacheline adapter. Serves one line transaction at a time.
// - Policy: D-cache has priority. An anti-starvation count forces an I-cache grant after STARVE_LIMIT consecutive D grants.

---
 rtl/line_mem_scheduler_if.sv | 30 +++
 rtl/line_mem_scheduler.sv | 107 ++++++++++
 tb/tb_line_mem_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/line_mem_scheduler_if.sv
// rtl/line_mem_scheduler_if.sv - I-cache, D-cache and adapter line signals shared by the scheduler.
interface line_mem_scheduler_if;
  logic         i_read;
  logic [31:0]  i_addr;
  logic         i_resp;
  logic [255:0] i_rdata;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic         d_resp;
  logic [255:0] d_rdata;
  logic         m_read;
  logic         m_write;
  logic [31:0]  m_addr;
  logic [255:0] m_wdata;
  logic         m_resp;
  logic [255:0] m_rdata;
  logic [1:0]   grant;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_resp, m_rdata,
    output i_resp, i_rdata, d_resp, d_rdata, m_read, m_write, m_addr, m_wdata, grant
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_resp, m_rdata,
    input  i_resp, i_rdata, d_resp, d_rdata, m_read, m_write, m_addr, m_wdata, grant
  );
endinterface

// File: rtl/line_mem_scheduler.sv
// rtl/line_mem_scheduler.sv - D-priority line port arbiter with I-cache anti-starvation.
module line_mem_scheduler #(
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 reset_n,
  line_mem_scheduler_if.slave bus
);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE, GAP} state_t;

  state_t       r_state, w_next;
  logic [3:0]   r_skip;
  logic         r_m_read, r_m_write, r_i_resp, r_d_resp;
  logic [31:0]  r_m_addr;
  logic [255:0] r_m_wdata, r_i_rdata, r_d_rdata;
  logic [1:0]   r_grant;
  logic         w_d_win, w_i_win;

  assign w_d_win = (bus.d_read | bus.d_write) &&
                   !(bus.i_read && (r_skip >= 4'(STARVE_LIMIT)));
  assign w_i_win = !w_d_win && bus.i_read;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:           if (w_d_win) w_next = BUSY_D;
                      else if (w_i_win) w_next = BUSY_I;
      BUSY_I, BUSY_D: if (bus.m_resp) w_next = DONE;
      DONE:           w_next = GAP;
      GAP:            w_next = IDLE;
      default:        w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_skip    <= '0;
      r_m_read  <= 1'b0;
      r_m_write <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_i_resp  <= 1'b0;
      r_d_resp  <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_grant   <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_d_win) begin
            // a write-back wins over a read when the D-cache raises both
            r_m_write <= bus.d_write;
            r_m_read  <= !bus.d_write;
            r_m_addr  <= bus.d_addr & ~32'h1F;
            r_m_wdata <= bus.d_wdata;
            r_grant   <= 2'b10;
            if (!bus.i_read)        r_skip <= '0;
            else if (r_skip != 4'hF) r_skip <= r_skip + 4'd1;
          end else if (w_i_win) begin
            r_m_read  <= 1'b1;
            r_m_write <= 1'b0;
            r_m_addr  <= bus.i_addr & ~32'h1F;
            r_m_wdata <= '0;
            r_grant   <= 2'b01;
            r_skip    <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.m_resp) begin
            r_m_read  <= 1'b0;
            r_m_write <= 1'b0;
            if (r_state == BUSY_I) begin
              r_i_resp  <= 1'b1;
              r_i_rdata <= bus.m_rdata;
            end else begin
              r_d_resp  <= 1'b1;
              r_d_rdata <= bus.m_rdata;
            end
          end
        end
        DONE: begin
          r_i_resp <= 1'b0;
          r_d_resp <= 1'b0;
          r_grant  <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign bus.m_read  = r_m_read;
  assign bus.m_write = r_m_write;
  assign bus.m_addr  = r_m_addr;
  assign bus.m_wdata = r_m_wdata;
  assign bus.i_resp  = r_i_resp;
  assign bus.i_rdata = r_i_rdata;
  assign bus.d_resp  = r_d_resp;
  assign bus.d_rdata = r_d_rdata;
  assign bus.grant   = r_grant;

endmodule

// File: tb/tb_line_mem_scheduler.sv
// tb/tb_line_mem_scheduler.sv - directed checks of arbitration, timing, starvation and reset.
module tb_line_mem_scheduler;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  line_mem_scheduler_if bus();

  line_mem_scheduler #(.STARVE_LIMIT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] PAT_A  = {8{32'hA5A5_0F0F}};
  localparam logic [255:0] DATA_I = {8{32'h1111_2222}} ^ 256'h1234;
  localparam logic [255:0] DATA_D = {8{32'hDEAD_BEEF}};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.m_read | bus.m_write) && n < 40);
    if (n >= 40) chk("req_timeout", 1'b0, 1'b1);
  endtask

  // adapter answers after dly cycles; checks the DONE and GAP cycles that follow
  task automatic serve(input logic [255:0] rd, input int dly, input logic is_i,
                       input logic drop_i, input logic drop_d);
    repeat (dly) @(negedge clk);
    chk("req_held", bus.m_read | bus.m_write, 1'b1);
    bus.m_rdata = rd;
    bus.m_resp  = 1'b1;
    @(negedge clk);
    bus.m_resp  = 1'b0;
    bus.m_rdata = '0;
    chk("done_mreq", {bus.m_read, bus.m_write}, 2'b00);
    chk("done_iresp", bus.i_resp, is_i);
    chk("done_dresp", bus.d_resp, !is_i);
    chk("done_rdata", is_i ? bus.i_rdata : bus.d_rdata, rd);
    chk("done_grant", bus.grant, is_i ? 2'b01 : 2'b10);
    if (drop_i) bus.i_read = 1'b0;
    if (drop_d) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
    @(negedge clk);
    chk("gap_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    chk("gap_grant", bus.grant, 2'b00);
  endtask

  initial begin
    int n;
    bus.i_read = 0; bus.i_addr = '0; bus.d_read = 0; bus.d_write = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.m_resp = 0; bus.m_rdata = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_mreq", {bus.m_read, bus.m_write}, 2'b00);
    chk("rst_addr", bus.m_addr, 32'h0);
    chk("rst_wdata", bus.m_wdata, 256'h0);
    chk("rst_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    chk("rst_rdata", bus.i_rdata | bus.d_rdata, 256'h0);
    chk("rst_grant", bus.grant, 2'b00);
    reset_n = 1'b1;
    @(negedge clk);

    // I-only read
    bus.i_read = 1; bus.i_addr = 32'h6000_0044;
    wait_req(n);
    chk("i_latency", n, 1);
    chk("i_addr", bus.m_addr, 32'h6000_0040);
    chk("i_rw", {bus.m_read, bus.m_write}, 2'b10);
    chk("i_grant", bus.grant, 2'b01);
    serve(DATA_I, 10, 1'b1, 1'b1, 1'b0);

    // D write-back
    bus.d_write = 1; bus.d_addr = 32'h1234_567F; bus.d_wdata = PAT_A;
    wait_req(n);
    chk("dw_latency", n, 2);
    chk("dw_rw", {bus.m_read, bus.m_write}, 2'b01);
    chk("dw_addr", bus.m_addr, 32'h1234_5660);
    chk("dw_wdata", bus.m_wdata, PAT_A);
    chk("dw_grant", bus.grant, 2'b10);
    serve(DATA_D, 3, 1'b0, 1'b0, 1'b1);

    // stray m_resp while idle is ignored
    @(negedge clk);
    bus.m_resp = 1; bus.m_rdata = DATA_I;
    @(negedge clk);
    bus.m_resp = 0;
    chk("stray_mreq", {bus.m_read, bus.m_write}, 2'b00);
    chk("stray_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    @(negedge clk);
    chk("stray_resp2", {bus.i_resp, bus.d_resp, bus.grant}, 4'b0000);

    // d_read and d_write together issue a write only
    bus.d_read = 1; bus.d_write = 1; bus.d_addr = 32'h0000_1FFF; bus.d_wdata = ~PAT_A;
    wait_req(n);
    chk("dual_rw", {bus.m_read, bus.m_write}, 2'b01);
    chk("dual_addr", bus.m_addr, 32'h0000_1FE0);
    chk("dual_wdata", bus.m_wdata, ~PAT_A);
    serve(PAT_A, 2, 1'b0, 1'b0, 1'b1);

    // simultaneous first request: D first, then I
    bus.i_read = 1; bus.i_addr = 32'h0000_0100; bus.d_read = 1; bus.d_addr = 32'h0000_0220;
    wait_req(n);
    chk("sim_d_grant", bus.grant, 2'b10);
    chk("sim_d_addr", bus.m_addr, 32'h0000_0220);
    serve(DATA_D, 1, 1'b0, 1'b0, 1'b1);
    wait_req(n);
    chk("sim_i_grant", bus.grant, 2'b01);
    chk("sim_i_addr", bus.m_addr, 32'h0000_0100);
    serve(DATA_I, 1, 1'b1, 1'b1, 1'b0);

    // starvation: four D grants, then I, then D again
    bus.i_read = 1; bus.i_addr = 32'h0000_3000; bus.d_read = 1; bus.d_addr = 32'h0000_4000;
    for (int g = 0; g < 4; g++) begin
      wait_req(n);
      chk($sformatf("starve_d%0d", g), bus.grant, 2'b10);
      serve(DATA_D ^ 256'(g), 1, 1'b0, 1'b0, 1'b0);
    end
    wait_req(n);
    chk("starve_i5", bus.grant, 2'b01);
    chk("starve_i5_addr", bus.m_addr, 32'h0000_3000);
    serve(DATA_I, 1, 1'b1, 1'b1, 1'b0);
    wait_req(n);
    chk("starve_d_after", bus.grant, 2'b10);
    serve(DATA_D, 1, 1'b0, 1'b0, 1'b1);

    // reset in the middle of a D read
    bus.d_read = 1; bus.d_addr = 32'h0000_5000;
    wait_req(n);
    chk("mid_busy", bus.m_read, 1'b1);
    reset_n = 0; bus.d_read = 0;
    @(negedge clk);
    chk("mid_rst_mreq", {bus.m_read, bus.m_write}, 2'b00);
    chk("mid_rst_addr", bus.m_addr, 32'h0);
    chk("mid_rst_grant", bus.grant, 2'b00);
    chk("mid_rst_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    reset_n = 1;
    @(negedge clk);
    chk("post_rst_resp", {bus.d_resp, bus.m_read}, 2'b00);
    bus.i_read = 1; bus.i_addr = 32'h0ABC_DEF5;
    wait_req(n);
    chk("post_rst_lat", n, 1);
    chk("post_rst_addr", bus.m_addr, 32'h0ABC_DEE0);
    chk("post_rst_grant", bus.grant, 2'b01);
    serve(DATA_I ^ PAT_A, 4, 1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
